// File: rtl/cpu_pkg.sv
// Shared CPU pipeline types.
//   fwd_sel_t   : EX operand source select (regfile / EX-MEM / MEM-WB).
//   mem_state_t : memory-wait FSM state.
//   REG_W_DEFAULT : default register-index width.
package cpu_pkg;

  localparam int REG_W_DEFAULT = 4;

  typedef enum logic [1:0] {
    FWD_RF    = 2'b00,
    FWD_EXMEM = 2'b01,
    FWD_MEMWB = 2'b10
  } fwd_sel_t;

  typedef enum logic {
    RUN  = 1'b0,
    WAIT = 1'b1
  } mem_state_t;

endpackage

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Saturating up-counter: holds at all-ones, never wraps.
//   clk : rising-edge clock
//   rst : synchronous reset, active-low
//   inc : count enable for this cycle
//   cnt : current count
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!rst)                    cnt_q <= '0;
    else if (inc && cnt_q != '1) cnt_q <= cnt_q + 1'b1;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard / forwarding / flush controller for the 5-stage pipeline.
//   id_rs/id_rt(+_used)     : sources of the instruction in ID
//   ex_*/mem_*/wb_*         : destinations in later stages
//   br_taken                : redirect resolved in MEM
//   mem_req/mem_ack         : MEM data access handshake
//   stall_if/stall_id       : hold PC / IF-ID
//   flush_ifid/idex/exmem   : bubble into that register
//   hold_all                : freeze the whole pipeline (memory wait)
//   fwd_a/fwd_b             : registered EX operand selects
//   mem_err                 : sticky memory timeout
//   stall_cnt/flush_cnt     : saturating performance counters
module pipe_hazard_ctrl
  import cpu_pkg::*;
#(
  parameter int REG_W       = cpu_pkg::REG_W_DEFAULT,
  parameter bit ZERO_REG    = 1'b1,
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_rs_used,
  input  logic             id_rt_used,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_wr,
  input  logic             ex_load,
  input  logic [REG_W-1:0] mem_rd,
  input  logic             mem_wr,
  input  logic [REG_W-1:0] wb_rd,
  input  logic             wb_wr,
  input  logic             br_taken,
  input  logic             mem_req,
  input  logic             mem_ack,
  output logic             stall_if,
  output logic             stall_id,
  output logic             flush_ifid,
  output logic             flush_idex,
  output logic             flush_exmem,
  output logic             hold_all,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int TW = 8;

  mem_state_t    state_q, state_d, state_eff;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic          retire_q, retire_d;
  logic          err_q, err_d;
  fwd_sel_t      fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;
  logic          lu, bubble, hold;

  function automatic logic match(input logic [REG_W-1:0] x, input logic [REG_W-1:0] y,
                                 input logic w);
    return w && (x == y) && !(ZERO_REG && (y == '0));
  endfunction

  // Newest producer wins: EX/MEM result over MEM/WB data.
  function automatic fwd_sel_t fwd_sel(input logic [REG_W-1:0] r);
    if (match(r, ex_rd, ex_wr))   return FWD_EXMEM;
    if (match(r, mem_rd, mem_wr)) return FWD_MEMWB;
    return FWD_RF;
  endfunction

  always_comb begin
    // Reset forces RUN for the combinational view so hold drops at once.
    state_eff = rst ? state_q : RUN;

    lu = ex_load && ((match(id_rs, ex_rd, ex_wr) && id_rs_used) ||
                     (match(id_rt, ex_rd, ex_wr) && id_rt_used));

    // An acking WAIT cycle lets the pipe advance. retire_q marks the cycle
    // after a timeout: the stuck access retires instead of re-entering WAIT.
    if (state_eff == WAIT) hold = !mem_ack;
    else                   hold = mem_req && !mem_ack && !retire_q;

    bubble = lu || br_taken;

    stall_if    = lu && !hold && !br_taken;
    stall_id    = stall_if;
    flush_ifid  = br_taken && !hold;
    flush_exmem = br_taken && !hold;
    flush_idex  = bubble && !hold;
    hold_all    = hold;

    state_d  = state_q;
    tcnt_d   = tcnt_q;
    retire_d = 1'b0;
    err_d    = err_q;
    fwd_a_d  = fwd_a_q;
    fwd_b_d  = fwd_b_q;

    case (state_q)
      RUN: begin
        if (mem_req && !mem_ack && !retire_q) begin
          state_d = WAIT;
          tcnt_d  = TW'(1);
        end
      end
      WAIT: begin
        if (mem_ack) begin
          state_d = RUN;
          tcnt_d  = '0;
        end else if (tcnt_q == TW'(MEM_TIMEOUT)) begin
          state_d  = RUN;
          tcnt_d   = '0;
          err_d    = 1'b1;
          retire_d = 1'b1;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end
      default: state_d = RUN;
    endcase

    if (!hold) begin
      fwd_a_d = bubble ? FWD_RF : fwd_sel(id_rs);
      fwd_b_d = bubble ? FWD_RF : fwd_sel(id_rt);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= RUN;
      tcnt_q   <= '0;
      retire_q <= 1'b0;
      err_q    <= 1'b0;
      fwd_a_q  <= FWD_RF;
      fwd_b_q  <= FWD_RF;
    end else begin
      state_q  <= state_d;
      tcnt_q   <= tcnt_d;
      retire_q <= retire_d;
      err_q    <= err_d;
      fwd_a_q  <= fwd_a_d;
      fwd_b_q  <= fwd_b_d;
    end
  end

  assign fwd_a   = fwd_a_q;
  assign fwd_b   = fwd_b_q;
  assign mem_err = err_q;

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .inc (stall_if || hold),
    .cnt (stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk (clk),
    .rst (rst),
    .inc (flush_exmem),
    .cnt (flush_cnt)
  );

  // WB is not a forwarding source (regfile writes before it reads); this
  // records when a load-use stall coincides with a WB producer of rs.
  cover property (@(posedge clk) disable iff (!rst)
    lu && match(id_rs, wb_rd, wb_wr) && id_rs_used);

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;
  localparam int REG_W = 4;
  localparam int TMO   = 16;
  localparam int CW    = 3;
  localparam int CMAX  = (1 << CW) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic [REG_W-1:0] id_rs, id_rt, ex_rd, mem_rd, wb_rd;
  logic id_rs_used, id_rt_used, ex_wr, ex_load, mem_wr, wb_wr;
  logic br_taken, mem_req, mem_ack;
  logic stall_if, stall_id, flush_ifid, flush_idex, flush_exmem, hold_all, mem_err;
  logic [1:0] fwd_a, fwd_b;
  logic [CW-1:0] stall_cnt, flush_cnt;

  pipe_hazard_ctrl #(.REG_W(REG_W), .ZERO_REG(1'b1), .MEM_TIMEOUT(TMO), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_rs_used(id_rs_used),
    .id_rt_used(id_rt_used), .ex_rd(ex_rd), .ex_wr(ex_wr), .ex_load(ex_load),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .wb_rd(wb_rd), .wb_wr(wb_wr), .br_taken(br_taken),
    .mem_req(mem_req), .mem_ack(mem_ack), .stall_if(stall_if), .stall_id(stall_id),
    .flush_ifid(flush_ifid), .flush_idex(flush_idex), .flush_exmem(flush_exmem),
    .hold_all(hold_all), .fwd_a(fwd_a), .fwd_b(fwd_b), .mem_err(mem_err),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt));

  int nchk = 0, nfail = 0;

  // Observed bundle: 6 control bits, fwd_a, fwd_b, mem_err, two counters.
  wire [16:0] obs = {stall_if, stall_id, flush_ifid, flush_idex, flush_exmem, hold_all,
                     fwd_a, fwd_b, mem_err, stall_cnt, flush_cnt};
  logic [16:0] exp_v;

  // Reference model state, kept as plain integers/flags.
  bit m_waiting, m_retire, m_err;
  int m_wait_n, m_sc, m_fc;
  int m_fa, m_fb;
  bit e_stall, e_fl_br, e_fl_idex, e_hold, e_lu;

  function automatic bit m_match(input int x, input int y, input bit w);
    return w && (x == y) && (y != 0);
  endfunction

  function automatic int m_sel(input int r);
    if (m_match(r, ex_rd, ex_wr))   return 1;
    if (m_match(r, mem_rd, mem_wr)) return 2;
    return 0;
  endfunction

  task automatic model_comb();
    e_lu = ex_load && ((m_match(id_rs, ex_rd, ex_wr) && id_rs_used) ||
                       (m_match(id_rt, ex_rd, ex_wr) && id_rt_used));
    if (rst && m_waiting) e_hold = !mem_ack;
    else                  e_hold = mem_req && !mem_ack && !m_retire;
    e_stall   = e_lu && !e_hold && !br_taken;
    e_fl_br   = br_taken && !e_hold;
    e_fl_idex = (e_lu || br_taken) && !e_hold;
    exp_v = {e_stall, e_stall, e_fl_br, e_fl_idex, e_fl_br, e_hold,
             2'(m_fa), 2'(m_fb), m_err, CW'(m_sc), CW'(m_fc)};
  endtask

  task automatic model_clk();
    if (!rst) begin
      m_waiting = 0; m_retire = 0; m_err = 0; m_wait_n = 0;
      m_sc = 0; m_fc = 0; m_fa = 0; m_fb = 0;
    end else begin
      if (e_stall || e_hold) m_sc = (m_sc < CMAX) ? m_sc + 1 : CMAX;
      if (e_fl_br)           m_fc = (m_fc < CMAX) ? m_fc + 1 : CMAX;
      if (!e_hold) begin
        m_fa = (e_lu || br_taken) ? 0 : m_sel(id_rs);
        m_fb = (e_lu || br_taken) ? 0 : m_sel(id_rt);
      end
      if (m_waiting) begin
        if (mem_ack) begin m_waiting = 0; m_wait_n = 0; end
        else if (m_wait_n == TMO) begin
          m_waiting = 0; m_wait_n = 0; m_err = 1; m_retire = 1;
        end else m_wait_n++;
      end else begin
        if (mem_req && !mem_ack && !m_retire) begin m_waiting = 1; m_wait_n = 1; end
        m_retire = 0;
      end
    end
  endtask

  // Evaluate model for current inputs and move to the sampling point.
  task automatic settle();
    model_comb();
    @(negedge clk);
  endtask

  task automatic advance();
    @(posedge clk);
    model_clk();
    #1;
  endtask

  task automatic idle_inputs();
    id_rs = 0; id_rt = 0; id_rs_used = 0; id_rt_used = 0;
    ex_rd = 0; ex_wr = 0; ex_load = 0; mem_rd = 0; mem_wr = 0;
    wb_rd = 0; wb_wr = 0; br_taken = 0; mem_req = 0; mem_ack = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 0;
    settle();
    advance();
    rst = 1;
  endtask

  task automatic test_reset();
    do_reset();
    settle();
    nchk++;
    if (obs !== 17'h0 || obs !== exp_v) begin
      nfail++; $display("FAIL reset_state obs=%h required=%h", obs, 17'h0);
    end
  endtask

  task automatic test_load_use();
    do_reset();
    ex_load = 1; ex_wr = 1; ex_rd = 3; id_rs = 3; id_rs_used = 1;
    settle();
    nchk++;
    if ({stall_if, stall_id, flush_idex, flush_ifid} !== 4'b1110 || obs !== exp_v) begin
      nfail++; $display("FAIL load_use_stall obs=%h model=%h", obs, exp_v);
    end
    advance();
    ex_load = 0; ex_rd = 4; mem_rd = 3; mem_wr = 1;
    settle();
    nchk++;
    if (stall_if !== 1'b0 || stall_cnt !== 3'd1 || obs !== exp_v) begin
      nfail++; $display("FAIL load_use_cnt stall_if=%b cnt=%0d obs=%h model=%h",
                        stall_if, stall_cnt, obs, exp_v);
    end
    advance();
    idle_inputs();
    settle();
    nchk++;
    if (fwd_a !== 2'b10 || obs !== exp_v) begin
      nfail++; $display("FAIL load_use_fwd fwd_a=%b required=10", fwd_a);
    end
    advance();
  endtask

  task automatic test_fwd_priority();
    do_reset();
    ex_rd = 5; mem_rd = 5; ex_wr = 1; mem_wr = 1; id_rt = 5; id_rt_used = 1;
    settle(); advance();
    settle();
    nchk++;
    if (fwd_b !== 2'b01 || obs !== exp_v) begin
      nfail++; $display("FAIL fwd_newest fwd_b=%b required=01", fwd_b);
    end
    ex_rd = 0; mem_rd = 0; id_rt = 0;
    advance();
    settle();
    nchk++;
    if (fwd_b !== 2'b00 || obs !== exp_v) begin
      nfail++; $display("FAIL fwd_zero_reg fwd_b=%b required=00", fwd_b);
    end
    advance();
  endtask

  task automatic test_branch();
    do_reset();
    // Prime a nonzero forward so the bubble clear is visible.
    mem_rd = 2; mem_wr = 1; id_rs = 2;
    settle(); advance();
    mem_wr = 0;
    br_taken = 1; ex_load = 1; ex_wr = 1; ex_rd = 3; id_rs = 3; id_rs_used = 1;
    settle();
    nchk++;
    if ({flush_ifid, flush_idex, flush_exmem, stall_if, stall_id} !== 5'b11100 ||
        obs !== exp_v) begin
      nfail++; $display("FAIL branch_flush obs=%h model=%h", obs, exp_v);
    end
    advance();
    idle_inputs();
    settle();
    nchk++;
    if (flush_cnt !== 3'd1 || fwd_a !== 2'b00 || fwd_b !== 2'b00 || obs !== exp_v) begin
      nfail++; $display("FAIL branch_after flush_cnt=%0d fwd_a=%b fwd_b=%b required 1/00/00",
                        flush_cnt, fwd_a, fwd_b);
    end
    advance();
  endtask

  task automatic test_mem_wait();
    do_reset();
    mem_req = 1;
    for (int i = 0; i < 4; i++) begin
      settle();
      nchk++;
      if (hold_all !== 1'b1 || obs !== exp_v) begin
        nfail++; $display("FAIL mem_wait_hold cyc=%0d hold=%b obs=%h model=%h",
                          i, hold_all, obs, exp_v);
      end
      advance();
    end
    mem_ack = 1;
    settle();
    nchk++;
    if (hold_all !== 1'b0 || obs !== exp_v) begin
      nfail++; $display("FAIL mem_wait_ack hold=%b required=0", hold_all);
    end
    advance();
    idle_inputs();
    settle();
    nchk++;
    if (stall_cnt !== 3'd4 || mem_err !== 1'b0 || obs !== exp_v) begin
      nfail++; $display("FAIL mem_wait_cnt stall_cnt=%0d err=%b required 4/0", stall_cnt, mem_err);
    end
    advance();
  endtask

  task automatic test_timeout();
    int held = 0;
    bit mism = 0;
    do_reset();
    mem_req = 1;
    for (int i = 0; i < 40; i++) begin
      settle();
      if (obs !== exp_v) mism = 1;
      if (!hold_all) break;
      held++;
      advance();
    end
    nchk++;
    if (held != TMO + 1 || mism) begin
      nfail++; $display("FAIL timeout_len held=%0d required=%0d model_mism=%b", held, TMO + 1, mism);
    end
    advance();
    mem_req = 0;
    for (int i = 0; i < 3; i++) begin settle(); advance(); end
    settle();
    nchk++;
    if (mem_err !== 1'b1 || obs !== exp_v) begin
      nfail++; $display("FAIL timeout_sticky mem_err=%b required=1", mem_err);
    end
    advance();
    do_reset();
    settle();
    nchk++;
    if (mem_err !== 1'b0) begin
      nfail++; $display("FAIL timeout_reset mem_err=%b required=0", mem_err);
    end
    advance();
  endtask

  task automatic test_saturation_reset();
    do_reset();
    ex_load = 1; ex_wr = 1; ex_rd = 7; id_rt = 7; id_rt_used = 1;
    for (int i = 0; i < 10; i++) begin settle(); advance(); end
    idle_inputs();
    settle();
    nchk++;
    if (stall_cnt !== 3'd7 || obs !== exp_v) begin
      nfail++; $display("FAIL stall_saturate stall_cnt=%0d required=7", stall_cnt);
    end
    advance();
    mem_req = 1;
    settle(); advance();
    settle(); advance();
    mem_req = 0; rst = 0;
    settle();
    nchk++;
    if (hold_all !== 1'b0) begin
      nfail++; $display("FAIL reset_mid_wait_hold hold=%b required=0", hold_all);
    end
    advance();
    rst = 1;
    settle();
    nchk++;
    if (obs !== 17'h0 || obs !== exp_v) begin
      nfail++; $display("FAIL reset_mid_wait_state obs=%h required=0", obs);
    end
    advance();
  endtask

  task automatic test_random(input int n, input int ack_pct);
    do_reset();
    for (int i = 0; i < n; i++) begin
      id_rs = REG_W'($urandom_range(0, 3)); id_rt = REG_W'($urandom_range(0, 3));
      ex_rd = REG_W'($urandom_range(0, 3)); mem_rd = REG_W'($urandom_range(0, 3));
      wb_rd = REG_W'($urandom_range(0, 3));
      id_rs_used = 1'($urandom); id_rt_used = 1'($urandom);
      ex_wr = 1'($urandom); ex_load = 1'($urandom); mem_wr = 1'($urandom);
      wb_wr = 1'($urandom);
      br_taken = ($urandom_range(0, 7) == 0);
      mem_req  = ($urandom_range(0, 5) == 0) || (m_waiting && $urandom_range(0, 9) != 0);
      mem_ack  = ($urandom_range(0, 99) < ack_pct);
      rst      = ($urandom_range(0, 79) != 0);
      settle();
      nchk++;
      if (obs !== exp_v) begin
        nfail++; $display("FAIL random cyc=%0d obs=%h model=%h", i, obs, exp_v);
      end
      advance();
    end
    rst = 1;
    idle_inputs();
  endtask

  initial begin
    rst = 1;
    idle_inputs();
    #1;
    test_reset();
    test_load_use();
    test_fwd_priority();
    test_branch();
    test_mem_wait();
    test_timeout();
    test_saturation_reset();
    test_random(400, 30);
    test_random(400, 4);
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
